// File: rtl/alu_seq.sv
// Registered ALU with single-cycle ops, an iterative shift-add multiply and a
// bit-serial variable left shift, behind a valid/ready request handshake.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] r_o,
    output logic [3:0]       flags_o
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, MUL, SHL} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [3:0]           flags_q, flags_d;

    logic [WIDTH:0]       alu_sum;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c;
    logic                 alu_v;
    logic [SW-1:0]        shamt;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     sh_next;

    assign shamt    = b_i[SW-1:0];
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign sh_next  = sh_q << 1;

    // Single-cycle result; op 15 only lands here for a zero shift count
    always_comb begin
        alu_sum = '0;
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_i)
            4'd0: begin
                alu_sum = {1'b0, a_i} + {1'b0, b_i};
                alu_r   = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
                alu_v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (alu_r[WIDTH-1] != a_i[WIDTH-1]);
            end
            4'd1: begin
                alu_r = a_i - b_i;
                alu_c = a_i < b_i;
                alu_v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (alu_r[WIDTH-1] != a_i[WIDTH-1]);
            end
            4'd2:  alu_r = a_i & b_i;
            4'd3:  alu_r = a_i | b_i;
            4'd4:  alu_r = a_i ^ b_i;
            4'd5:  alu_r = ~a_i;
            4'd6:  alu_r = ~b_i;
            4'd7:  alu_r = a_i;
            4'd8:  alu_r = b_i;
            4'd9: begin
                alu_r = a_i << 1;
                alu_c = a_i[WIDTH-1];
            end
            4'd10: begin
                alu_r = a_i >> 1;
                alu_c = a_i[0];
            end
            4'd12: begin
                alu_sum = {1'b0, a_i} + {1'b0, ONE};
                alu_r   = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
                alu_v   = ~a_i[WIDTH-1] & alu_r[WIDTH-1];
            end
            4'd13: begin
                alu_r = a_i - ONE;
                alu_c = (a_i == '0);
                alu_v = a_i[WIDTH-1] & ~alu_r[WIDTH-1];
            end
            4'd15: alu_r = a_i;
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        r_d      = r_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (op_i == 4'd14 && MUL_EN != 0) begin
                        state_d  = MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a_i};
                        mplier_d = b_i;
                        cnt_d    = CW'(WIDTH);
                    end else if (op_i == 4'd15 && shamt != '0) begin
                        state_d = SHL;
                        sh_d    = a_i;
                        cnt_d   = CW'(shamt);
                    end else begin
                        valid_d = 1'b1;
                        r_d     = alu_r;
                        flags_d = {alu_r[WIDTH-1], alu_r == '0, alu_c, alu_v};
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    r_d     = acc_step[WIDTH-1:0];
                    flags_d = {acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0,
                               |acc_step[2*WIDTH-1:WIDTH], 1'b0};
                end
            end
            SHL: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - CW'(1);
                // Carry is whichever bit falls off on the final step
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    r_d     = sh_next;
                    flags_d = {sh_next[WIDTH-1], sh_next == '0, sh_q[WIDTH-1], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            r_q      <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            r_q      <= r_d;
            flags_q  <= flags_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = valid_q;
    assign r_o     = r_q;
    assign flags_o = flags_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the team's 8-bit combinational ALU. It keeps opcodes 0-13 with identical semantics and adds multi-cycle unsigned multiply and variable left shift. It also adds a status-flag output and a valid/ready handshake. It sits between the register file and the writeback stage of the next-generation datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of two).
MUL_EN, 1, 1 = op 14 is an iterative multiply; 0 = op 14 completes in 1 cycle with r_o=0, flags per zero result.

Ports:
clk_i  input  1  clock, all state on rising edge.
rst_i  input  1  synchronous, active-high reset.
valid_i  input  1  operation request; accepted when valid_i && ready_o.
ready_o  output  1  1 = idle, can accept an op.
a_i  input  WIDTH  operand A, sampled on accept.
b_i  input  WIDTH  operand B, sampled on accept.
op_i  input  4  opcode, sampled on accept.
valid_o  output  1  one-cycle pulse: r_o/flags_o updated this cycle.
r_o  output  WIDTH  registered result, held until next completion.
flags_o  output  4  {N,Z,C,V}, registered with r_o.

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE, ready_o=1, valid_o=0, r_o=0, flags_o=0. Any op in flight is aborted, and no valid_o is produced for it.
- FSM states: IDLE, MUL, SHL.
- IDLE, accept of op 0-13 (or op 14 with MUL_EN=0): result and flags are registered at that edge. valid_o=1 the next cycle (latency 1) and ready_o stays 1, so back-to-back accepts give one result per cycle.
- IDLE, accept of op 14 (MUL_EN=1): go to MUL and latch a, b. Counter=WIDTH. ready_o=0 while in MUL.
- IDLE, accept of op 15: go to SHL with count = b_i[log2(WIDTH)-1:0]. A count of 0 completes like a 1-cycle op.
- valid_i while ready_o=0 is ignored: not queued, no effect.
- Opcodes, all arithmetic modulo 2^WIDTH:
  - 0 a+b; 1 a-b; 2 a&b; 3 a|b; 4 a^b; 5 ~a; 6 ~b; 7 a; 8 b.
  - 9 a<<1; 10 a>>1 (logical); 11 0; 12 a+1; 13 a-1.
  - 14 unsigned a*b, low WIDTH bits.
  - 15 a << (b mod WIDTH), logical.
- MUL: shift-add, one multiplier bit per cycle, for exactly WIDTH cycles.
  - On the last iteration: return to IDLE, register the result, pulse valid_o next cycle.
  - Accept-to-valid_o latency = WIDTH+1 cycles.
- SHL: shift one bit per cycle for count cycles. Latency = count+1 cycles (count>=1).
- Flags:
  - N = r[WIDTH-1]; Z = (r==0).
  - C for 0 and 12: carry-out of bit WIDTH-1.
  - C for 1 and 13: borrow, 1 iff a<b (resp. a==0).
  - C for 9: a[WIDTH-1]; for 10: a[0].
  - C for 14: 1 iff the upper WIDTH bits of the full product are nonzero.
  - C for 15: the last bit shifted out.
  - C = 0 for all other ops.
  - V for 0, 1, 12, 13: two's-complement signed overflow. V = 0 for all other ops.
- Unknown opcodes: none, since all 16 are defined.
- Sampled operands are held internally. Changing a_i/b_i/op_i after accept has no effect.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles with valid_i=1 -> r_o=0, flags_o=0, valid_o=0, ready_o=1 throughout; no accept during reset.
- Add/sub flags, WIDTH=8:
  - op0 a=0x7F b=0x01 -> r_o=0x80, N=1 Z=0 C=0 V=1, valid_o one cycle after accept.
  - op0 0xFF+0x01 -> 0x00, Z=1 C=1 V=0.
  - op1 0x00-0x01 -> 0xFF, N=1 C=1.
- Back-to-back: ops 2,3,4 with a=0xF0 b=0x3C on consecutive cycles -> r_o=0x30, 0xFC, 0xCC on three consecutive valid_o cycles; ready_o never drops.
- Multiply: op14 a=0x13 b=0x0E -> ready_o=0 for 8 cycles, then r_o=0x0A, C=1 (product 0x10A), valid_o exactly 9 cycles after accept. A valid_i issued mid-op is ignored.
- Variable shift:
  - op15 a=0x81 b=0x03 -> r_o=0x08, C=0, latency 4.
  - b=0x08 (count 0) -> r_o=0x81, latency 1.
  - a=0x81 b=0x01 -> r_o=0x02, C=1.
- Reset mid-multiply: assert rst_i 3 cycles into op14 -> no valid_o, r_o=0, ready_o=1 the cycle after reset. A subsequent op12 a=0xFF -> r_o=0x00, Z=1 C=1.
